// File: rtl/svc_rv_hazard_ctrl.sv
// svc_rv_hazard_ctrl: stall/flush control for hazards EX forwarding cannot cover, plus multi-cycle
// EX sequencing with a watchdog. Defining SVC_RV_HAZARD_STATS_EN adds saturating event counters.
module svc_rv_hazard_ctrl #(
  parameter int FWD        = 1,
  parameter int MEM_TYPE   = 0,
  parameter int MC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       reg_write_ex,
  input  logic [2:0] res_src_ex,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_mem,
  input  logic [2:0] res_src_mem,
  input  logic       redirect_ex,
  input  logic       mc_start_ex,
  input  logic       mc_done,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       bubble_mem,
  output logic       mc_busy,
  output logic       mc_err
`ifdef SVC_RV_HAZARD_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_mc_cycles
`endif
);

  localparam logic [2:0] SRC_LOAD = 3'd1;
  localparam logic [2:0] SRC_CSR  = 3'd4;

  localparam int                 CNT_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((MC_TIMEOUT > 0) ? (MC_TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic               WD_EN    = (MC_TIMEOUT > 0);

  // Control vector order: {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem}
  localparam logic [5:0] CTL_NONE  = 6'b000000;
  localparam logic [5:0] CTL_REDIR = 6'b000110;
  localparam logic [5:0] CTL_HAZ   = 6'b110010;
  localparam logic [5:0] CTL_HOLD  = 6'b111001;
  localparam logic [5:0] CTL_ABORT = 6'b000011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic             match_ex_s;
  logic             match_mem_s;
  logic             hazard_s;
  logic             timeout_s;
  logic [5:0]       ctl_s;

  // RAW detection against EX/MEM writers whose value cannot be forwarded into ID's consumer yet
  always_comb begin
    match_ex_s  = reg_write_ex && (rd_ex != 5'd0) && ((rs1_id == rd_ex) || (rs2_id == rd_ex));
    match_mem_s = reg_write_mem && (rd_mem != 5'd0) && ((rs1_id == rd_mem) || (rs2_id == rd_mem));
    hazard_s    = (match_ex_s && ((FWD == 0) || (res_src_ex == SRC_LOAD) || (res_src_ex == SRC_CSR)))
               || (match_mem_s && ((FWD == 0) || (res_src_mem == SRC_CSR)
                                   || ((res_src_mem == SRC_LOAD) && (MEM_TYPE == 1))));
    timeout_s   = WD_EN && (cnt_r == CNT_LAST);
  end

  // Pipeline control decode; redirect outranks everything since ID then holds a wrong-path op
  always_comb begin
    ctl_s = CTL_NONE;
    if (rst) begin
      ctl_s = CTL_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (redirect_ex) begin
            ctl_s = CTL_REDIR;
          end else if (mc_start_ex) begin
            ctl_s = CTL_HOLD;
          end else if (hazard_s) begin
            ctl_s = CTL_HAZ;
          end else begin
            ctl_s = CTL_NONE;
          end
        end
        ST_BUSY: begin
          if (mc_done) begin
            ctl_s = CTL_NONE;
          end else if (timeout_s) begin
            ctl_s = CTL_ABORT;
          end else begin
            ctl_s = CTL_HOLD;
          end
        end
        default: ctl_s = CTL_NONE;
      endcase
    end
  end

  assign {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem} = ctl_s;
  assign mc_busy = (state_r == ST_BUSY);
  assign mc_err  = err_r;

  // Multi-cycle sequencer with watchdog; a done in the timeout cycle takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mc_start_ex && !redirect_ex) begin
            state_r <= ST_BUSY;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          if (mc_done) begin
            state_r <= ST_IDLE;
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef SVC_RV_HAZARD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cycles <= 32'd0;
      stat_flushes      <= 32'd0;
      stat_mc_cycles    <= 32'd0;
    end else begin
      stat_stall_cycles <= sat_inc(stat_stall_cycles, stall_id);
      stat_flushes      <= sat_inc(stat_flushes, flush_id);
      stat_mc_cycles    <= sat_inc(stat_mc_cycles, mc_busy);
    end
  end
`endif

endmodule
